tx_uart: RTL

TX_UART -- requirements
Module: tx_uart

---
 rtl/tx_uart.sv | 138 +++++++++++++
 1 files changed

// File: rtl/tx_uart.sv
// 8N1 UART transmitter with a small byte FIFO in front of the shifter.
// Baud is chosen per frame from sel_baud at the moment the frame is loaded.
module tx_uart #(
  parameter int CLK_RATE   = 1000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] sel_baud,
  input  logic [7:0] i_Data,
  input  logic       i_Valid,
  output logic       o_Ready,
  output logic       o_Tx,
  output logic       o_Busy,
  output logic       o_Done
);

  localparam int DIV_MAX = (CLK_RATE / 9600 < 2) ? 2 : CLK_RATE / 9600;
  localparam int DW      = $clog2(DIV_MAX + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  function automatic logic [DW-1:0] div_for(input logic [3:0] sel);
    int baud;
    int d;
    case (sel)
      4'd1:    baud = 19200;
      4'd2:    baud = 38400;
      4'd3:    baud = 57600;
      4'd4:    baud = 115200;
      default: baud = 9600;
    endcase
    d = CLK_RATE / baud;
    if (d < 2) d = 2;
    return DW'(d);
  endfunction

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  state_t        state_q;
  logic [7:0]    shift_q;
  logic [DW-1:0] div_q, div_cnt_q;
  logic [3:0]    bit_cnt_q;
  logic          tx_q, done_q;
  logic          push, pop, bit_end;

  assign o_Ready = (count_q != CW'(FIFO_DEPTH));
  assign o_Busy  = (state_q != IDLE) || (count_q != '0);
  assign o_Tx    = tx_q;
  assign o_Done  = done_q;

  assign push    = i_Valid && o_Ready;
  assign bit_end = (div_cnt_q == div_q - DW'(1));
  // A new frame is loaded from IDLE, or straight out of the final stop cycle.
  assign pop     = (count_q != '0) &&
                   ((state_q == IDLE) || ((state_q == STOP) && bit_end));

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= i_Data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      shift_q   <= '0;
      div_q     <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);

      if (pop) begin
        shift_q   <= mem[rd_ptr_q];
        div_q     <= div_for(sel_baud);
        div_cnt_q <= '0;
        bit_cnt_q <= '0;
        tx_q      <= 1'b0;
        state_q   <= START;
      end else begin
        case (state_q)
          IDLE: tx_q <= 1'b1;
          START: begin
            if (bit_end) begin
              div_cnt_q <= '0;
              bit_cnt_q <= '0;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              state_q   <= DATA;
            end else begin
              div_cnt_q <= div_cnt_q + DW'(1);
            end
          end
          DATA: begin
            if (bit_end) begin
              div_cnt_q <= '0;
              if (bit_cnt_q == 4'd7) begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 4'd1;
                tx_q      <= shift_q[0];
                shift_q   <= shift_q >> 1;
              end
            end else begin
              div_cnt_q <= div_cnt_q + DW'(1);
            end
          end
          STOP: begin
            if (bit_end) begin
              done_q    <= 1'b1;
              div_cnt_q <= '0;
              tx_q      <= 1'b1;
              state_q   <= IDLE;
            end else begin
              div_cnt_q <= div_cnt_q + DW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
        if (state_q == STOP && bit_end) done_q <= 1'b1;
      end
      if (pop && state_q == STOP) done_q <= 1'b1;
    end
  end

endmodule
